// File: rtl/lu_row_buffer_if.sv
// ==========================================================================
// lu_row_buffer_if : load / read / write-back / drain bundle for lu_row_buffer (rev 1.0)
// ==========================================================================
`default_nettype none

interface lu_row_buffer_if #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 64
);
  localparam int RW = SIZE * 2 * WIDTH;
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic          flush_i;
  logic [RW-1:0] load_row_i;
  logic [AW-1:0] load_addr_i;
  logic          load_valid_i;
  logic          load_ready_o;
  logic [AW-1:0] rd_addr_i;
  logic          rd_addr_valid_i;
  logic [RW-1:0] rd_row_o;
  logic [AW-1:0] rd_addr_o;
  logic          rd_valid_o;
  logic [RW-1:0] wr_row_i;
  logic [AW-1:0] wr_addr_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic          done_i;
  logic [RW-1:0] out_row_o;
  logic [AW-1:0] out_addr_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          full_o;
  logic          busy_o;

  modport master (
    output flush_i, load_row_i, load_addr_i, load_valid_i,
    output rd_addr_i, rd_addr_valid_i,
    output wr_row_i, wr_addr_i, wr_valid_i,
    output done_i, out_ready_i,
    input  load_ready_o, rd_row_o, rd_addr_o, rd_valid_o, wr_ready_o,
    input  out_row_o, out_addr_o, out_valid_o, full_o, busy_o
  );

  modport slave (
    input  flush_i, load_row_i, load_addr_i, load_valid_i,
    input  rd_addr_i, rd_addr_valid_i,
    input  wr_row_i, wr_addr_i, wr_valid_i,
    input  done_i, out_ready_i,
    output load_ready_o, rd_row_o, rd_addr_o, rd_valid_o, wr_ready_o,
    output out_row_o, out_addr_o, out_valid_o, full_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/lu_row_buffer.sv
// ==========================================================================
// lu_row_buffer : SIZE-row complex matrix store between loader, LU engine and drain (rev 1.0)
// ==========================================================================
`default_nettype none

module lu_row_buffer #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 64
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  lu_row_buffer_if.slave  bus
);
  localparam int RW = SIZE * 2 * WIDTH;
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] bitmap_q, bitmap_d;
  logic [RW-1:0]   rows_q [SIZE];
  logic [RW-1:0]   rows_d [SIZE];
  logic [AW-1:0]   drain_idx_q, drain_idx_d;
  logic            rd_valid_q, rd_valid_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [RW-1:0]   rd_row_q, rd_row_d;
  logic            load_acc, wr_acc;

  always_comb begin
    state_d     = state_q;
    bitmap_d    = bitmap_q;
    rows_d      = rows_q;
    drain_idx_d = drain_idx_q;
    rd_valid_d  = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_row_d    = rd_row_q;

    load_acc = bus.load_valid_i && !bus.flush_i &&
               ((state_q == ST_EMPTY) || (state_q == ST_LOADING));
    wr_acc   = bus.wr_valid_i && !bus.flush_i && (state_q == ST_ACTIVE);

    if (load_acc) begin
      rows_d[bus.load_addr_i]   = bus.load_row_i;
      bitmap_d[bus.load_addr_i] = 1'b1;
    end
    if (wr_acc) begin
      rows_d[bus.wr_addr_i] = bus.wr_row_i;
    end

    // Read from the post-write image so a same-cycle write is returned.
    if ((state_q == ST_ACTIVE) && bus.rd_addr_valid_i && !bus.flush_i) begin
      rd_valid_d = 1'b1;
      rd_addr_d  = bus.rd_addr_i;
      rd_row_d   = rows_d[bus.rd_addr_i];
    end

    case (state_q)
      ST_EMPTY: begin
        if (load_acc) begin
          state_d = (&bitmap_d) ? ST_ACTIVE : ST_LOADING;
        end
      end
      ST_LOADING: begin
        if (&bitmap_d) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (bus.done_i) begin
          state_d     = ST_DRAIN;
          drain_idx_d = '0;
        end
      end
      ST_DRAIN: begin
        if (bus.out_ready_i) begin
          if (drain_idx_q == AW'(SIZE - 1)) begin
            state_d  = ST_EMPTY;
            bitmap_d = '0;
          end else begin
            drain_idx_d = drain_idx_q + AW'(1);
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (bus.flush_i) begin
      state_d  = ST_EMPTY;
      bitmap_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      bitmap_q    <= '0;
      drain_idx_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      rd_row_q    <= '0;
    end else begin
      state_q     <= state_d;
      bitmap_q    <= bitmap_d;
      drain_idx_q <= drain_idx_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      rd_row_q    <= rd_row_d;
    end
  end

  // Row storage is deliberately left unreset; the bitmap gates its validity.
  always_ff @(posedge clk_i) begin
    rows_q <= rows_d;
  end

  assign bus.load_ready_o = (state_q == ST_EMPTY) || (state_q == ST_LOADING);
  assign bus.wr_ready_o   = (state_q == ST_ACTIVE);
  assign bus.full_o       = (state_q == ST_ACTIVE);
  assign bus.busy_o       = (state_q != ST_EMPTY);
  assign bus.rd_valid_o   = rd_valid_q;
  assign bus.rd_addr_o    = rd_addr_q;
  assign bus.rd_row_o     = rd_row_q;
  assign bus.out_valid_o  = (state_q == ST_DRAIN);
  assign bus.out_addr_o   = (state_q == ST_DRAIN) ? drain_idx_q : '0;
  assign bus.out_row_o    = (state_q == ST_DRAIN) ? rows_q[drain_idx_q] : '0;

endmodule

`default_nettype wire

// File: tb/tb_lu_row_buffer.sv
// ==========================================================================
// tb_lu_row_buffer : directed + randomized checks of lu_row_buffer against a row-array model (rev 1.0)
// ==========================================================================
`default_nettype none

module tb_lu_row_buffer;
  localparam int SIZE  = 4;
  localparam int WIDTH = 64;
  localparam int RW    = SIZE * 2 * WIDTH;
  localparam int AW    = $clog2(SIZE);

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [RW-1:0] model [SIZE];

  lu_row_buffer_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

  lu_row_buffer #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] spec_row(input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int j = 0; j < SIZE; j++) begin
      v[j*2*WIDTH +: 2*WIDTH] = {$realtobits(real'(j)), $realtobits(real'(r + j))};
    end
    return v;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] v;
    for (int k = 0; k < RW / 32; k++) begin
      v[k*32 +: 32] = $urandom;
    end
    return v;
  endfunction

  task automatic load_beat(input int a, input logic [RW-1:0] d);
    bus.load_valid_i = 1'b1;
    bus.load_addr_i  = AW'(a);
    bus.load_row_i   = d;
    model[a]         = d;
    step();
    bus.load_valid_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_load_ready"}, RW'(bus.load_ready_o), RW'(1));
    check({tag, "_busy"},       RW'(bus.busy_o),       RW'(0));
    check({tag, "_full"},       RW'(bus.full_o),       RW'(0));
    check({tag, "_wr_ready"},   RW'(bus.wr_ready_o),   RW'(0));
    check({tag, "_rd_valid"},   RW'(bus.rd_valid_o),   RW'(0));
    check({tag, "_out_valid"},  RW'(bus.out_valid_o),  RW'(0));
  endtask

  initial begin
    int            order [5];
    int            idx;
    bit            rdy;
    int            wa, ra;
    logic [RW-1:0] d, one_row, exp_row;

    bus.flush_i = 0; bus.load_row_i = '0; bus.load_addr_i = '0; bus.load_valid_i = 0;
    bus.rd_addr_i = '0; bus.rd_addr_valid_i = 0; bus.wr_row_i = '0; bus.wr_addr_i = '0;
    bus.wr_valid_i = 0; bus.done_i = 0; bus.out_ready_i = 0;

    step(); step();
    rst_i = 1'b0;
    check_idle("reset");
    check("reset_rd_row",   bus.rd_row_o,        '0);
    check("reset_out_row",  bus.out_row_o,       '0);
    check("reset_out_addr", RW'(bus.out_addr_o), '0);
    check("reset_rd_addr",  RW'(bus.rd_addr_o),  '0);

    // Row 3 loaded twice: second beat overwrites, fill still needs all four.
    order = '{3, 3, 1, 0, 2};
    bus.rd_addr_valid_i = 1'b1;
    bus.rd_addr_i = '0;
    for (int b = 0; b < 5; b++) begin
      load_beat(order[b], (b == 0) ? rand_row() : spec_row(order[b]));
      check("load_rd_ignored", RW'(bus.rd_valid_o), RW'(0));
      if (b < 4) begin
        check("load_full_low",  RW'(bus.full_o),       RW'(0));
        check("load_ready_hi",  RW'(bus.load_ready_o), RW'(1));
        check("load_busy",      RW'(bus.busy_o),       RW'(1));
      end
    end
    check("full_after_last", RW'(bus.full_o),       RW'(1));
    check("ready_after_full", RW'(bus.load_ready_o), RW'(0));
    check("wr_ready_active", RW'(bus.wr_ready_o),   RW'(1));

    for (int k = 0; k < SIZE; k++) begin
      bus.rd_addr_i = AW'(k);
      bus.rd_addr_valid_i = 1'b1;
      step();
      check("rd_valid_seq", RW'(bus.rd_valid_o), RW'(1));
      check("rd_addr_seq",  RW'(bus.rd_addr_o),  RW'(k));
      check("rd_row_seq",   bus.rd_row_o,        model[k]);
    end
    bus.rd_addr_valid_i = 1'b0;
    step();
    check("rd_valid_drop", RW'(bus.rd_valid_o), RW'(0));

    // Write-first: a write of 1.0+j0 to row 2 while row 2 is read.
    one_row = '0;
    for (int j = 0; j < SIZE; j++) begin
      one_row[j*2*WIDTH +: 2*WIDTH] = {$realtobits(0.0), $realtobits(1.0)};
    end
    bus.wr_valid_i = 1'b1; bus.wr_addr_i = AW'(2); bus.wr_row_i = one_row;
    bus.rd_addr_valid_i = 1'b1; bus.rd_addr_i = AW'(2);
    model[2] = one_row;
    step();
    check("bypass_row", bus.rd_row_o, one_row);
    check("bypass_vld", RW'(bus.rd_valid_o), RW'(1));

    for (int n = 0; n < 24; n++) begin
      wa = $urandom_range(SIZE - 1);
      ra = $urandom_range(SIZE - 1);
      d  = rand_row();
      bus.wr_valid_i = 1'($urandom_range(1));
      bus.wr_addr_i = AW'(wa); bus.wr_row_i = d;
      bus.rd_addr_i = AW'(ra); bus.rd_addr_valid_i = 1'b1;
      if (bus.wr_valid_i) model[wa] = d;
      exp_row = model[ra];
      step();
      check("rand_rd_row",  bus.rd_row_o,       exp_row);
      check("rand_rd_addr", RW'(bus.rd_addr_o), RW'(ra));
    end
    bus.rd_addr_valid_i = 1'b0;

    // Write accepted in the done cycle must appear in the drain.
    d = rand_row();
    bus.wr_valid_i = 1'b1; bus.wr_addr_i = '0; bus.wr_row_i = d;
    model[0] = d;
    bus.done_i = 1'b1;
    step();
    bus.done_i = 1'b0; bus.wr_valid_i = 1'b0;
    check("drain_wr_ready", RW'(bus.wr_ready_o), RW'(0));
    check("drain_full",     RW'(bus.full_o),     RW'(0));
    bus.rd_addr_valid_i = 1'b1;
    idx = 0;
    rdy = 1'b1;
    for (int n = 0; n < 16 && idx < SIZE; n++) begin
      check("drain_valid", RW'(bus.out_valid_o), RW'(1));
      check("drain_addr",  RW'(bus.out_addr_o),  RW'(idx));
      check("drain_row",   bus.out_row_o,        model[idx]);
      check("drain_busy",  RW'(bus.busy_o),      RW'(1));
      check("drain_no_rd", RW'(bus.rd_valid_o),  RW'(0));
      bus.out_ready_i = rdy;
      step();
      if (rdy) idx++;
      rdy = !rdy;
    end
    bus.out_ready_i = 1'b0;
    bus.rd_addr_valid_i = 1'b0;
    check("drain_count", RW'(idx), RW'(SIZE));
    check_idle("after_drain");

    for (int k = 0; k < SIZE; k++) load_beat(k, rand_row());
    check("reload_full", RW'(bus.full_o), RW'(1));

    bus.flush_i = 1'b1;
    bus.rd_addr_valid_i = 1'b1; bus.rd_addr_i = AW'(1);
    bus.wr_valid_i = 1'b1; bus.wr_addr_i = AW'(1); bus.wr_row_i = rand_row();
    step();
    bus.flush_i = 1'b0; bus.rd_addr_valid_i = 1'b0; bus.wr_valid_i = 1'b0;
    check_idle("flush");

    order = '{2, 0, 3, 1, 0};
    for (int b = 0; b < SIZE; b++) begin
      load_beat(order[b], rand_row());
      check("refill_full", RW'(bus.full_o), RW'(b == SIZE - 1));
    end
    bus.rd_addr_valid_i = 1'b1; bus.rd_addr_i = AW'(1);
    step();
    bus.rd_addr_valid_i = 1'b0;
    check("refill_rd_row", bus.rd_row_o, model[1]);

    bus.done_i = 1'b1;
    step();
    bus.done_i = 1'b0;
    bus.out_ready_i = 1'b1;
    step(); step();
    check("pre_rst_addr",  RW'(bus.out_addr_o),  RW'(2));
    check("pre_rst_valid", RW'(bus.out_valid_o), RW'(1));
    rst_i = 1'b1;
    step();
    check_idle("drain_rst");
    check("drain_rst_out_row",  bus.out_row_o,       '0);
    check("drain_rst_out_addr", RW'(bus.out_addr_o), '0);
    check("drain_rst_rd_row",   bus.rd_row_o,        '0);
    rst_i = 1'b0;
    bus.out_ready_i = 1'b0;
    step();
    check_idle("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lu_row_buffer.md
LU_ROW_BUFFER -- requirements
Module: lu_row_buffer

Interface
REQ-001 SHALL have parameter SIZE, default 4, matrix dimension (rows, and complex elements per row).
REQ-002 SHALL have parameter WIDTH, default 64, bits per real/imag part; row width RW = SIZE*2*WIDTH, element j = {imag,real} at bits [j*2*WIDTH +: 2*WIDTH].
REQ-003 SHALL have port clk_i  in  1  the single clock.
REQ-004 SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-005 SHALL have port flush_i  in  1  abort current matrix; return to EMPTY.
REQ-006 SHALL have port load_row_i  in  RW  row from upstream loader.
REQ-007 SHALL have port load_addr_i  in  $clog2(SIZE)  row index of load_row_i.
REQ-008 SHALL have port load_valid_i  in  1  load beat valid.
REQ-009 SHALL have port load_ready_o  out  1  buffer accepts load beats.
REQ-010 SHALL have port rd_addr_i  in  $clog2(SIZE)  row read request from LU engine.
REQ-011 SHALL have port rd_addr_valid_i  in  1  read request valid.
REQ-012 SHALL have port rd_row_o / rd_addr_o / rd_valid_o  out  RW / $clog2(SIZE) / 1  read response to LU engine.
REQ-013 SHALL have port wr_row_i / wr_addr_i / wr_valid_i  in  RW / $clog2(SIZE) / 1  row write-back from LU engine.
REQ-014 SHALL have port wr_ready_o  out  1  write-back accepted.
REQ-015 SHALL have port done_i  in  1  LU engine finished; start drain.
REQ-016 SHALL have port out_row_o / out_addr_o / out_valid_o  out  RW / $clog2(SIZE) / 1  drained row to downstream.
REQ-017 SHALL have port out_ready_i  in  1  downstream accepts drained row.
REQ-018 SHALL have port full_o / busy_o  out  1 / 1  all rows loaded and in ACTIVE / state != EMPTY.

Function
REQ-019 SHALL implement FSM states EMPTY, LOADING, ACTIVE, DRAIN, plus an SIZE-bit loaded bitmap.
REQ-020 SHALL assert load_ready_o only in EMPTY and LOADING; a beat transfers when load_valid_i && load_ready_o, writing row load_addr_i and setting its bitmap bit.
REQ-021 SHALL go EMPTY->LOADING on first accepted beat; LOADING->ACTIVE the cycle after the bitmap becomes all ones.
REQ-022 SHALL overwrite a row on a repeated load address, bitmap unchanged.
REQ-023 SHALL, in ACTIVE, respond to rd_addr_valid_i with rd_valid_o=1, rd_addr_o=rd_addr_i, rd_row_o=row contents exactly 1 cycle later, one response per request, back-to-back every cycle.
REQ-024 SHALL ignore read requests outside ACTIVE (rd_valid_o stays 0).
REQ-025 SHALL hold wr_ready_o=1 only in ACTIVE; accepted write updates row wr_addr_i at the clock edge.
REQ-026 SHALL, on read and write to the same address in the same cycle, return the newly written data (write-first bypass).
REQ-027 SHALL go ACTIVE->DRAIN on done_i; done_i ignored in other states; a write accepted in the done_i cycle is included in the drain.
REQ-028 SHALL, in DRAIN, present rows 0..SIZE-1 in order, out_valid_o=1, holding row/address stable while out_ready_i=0.
REQ-029 SHALL, after row SIZE-1 is accepted, go to EMPTY next cycle, clear bitmap, drop out_valid_o.
REQ-030 SHALL, on flush_i in any state, go to EMPTY next cycle, clear bitmap, deassert rd_valid_o/out_valid_o; row storage contents not cleared; flush_i has priority over load, write, done_i.
REQ-031 SHALL assert full_o exactly when state is ACTIVE; busy_o when state != EMPTY.

Reset
REQ-032 SHALL, on rst_i, enter EMPTY, clear bitmap, drive rd_valid_o=0, out_valid_o=0, wr_ready_o=0, full_o=0, busy_o=0, load_ready_o=1, rd_row_o/out_row_o/addr outputs=0; rst_i has priority over flush_i.
REQ-033 SHALL honour reset mid-LOADING/ACTIVE/DRAIN identically; no drained row completes after reset.

Verification
REQ-034 Load rows 3,1,0,2 (row r = elements r+j+j·i as doubles) -> full_o=1 one cycle after row 2 beat; load_ready_o=0 thereafter.
REQ-035 ACTIVE, rd_addr 0,1,2,3 on consecutive cycles -> rd_valid_o 4 consecutive cycles, each one cycle later, matching rows.
REQ-036 ACTIVE, write row 2 = all 1.0+j0 while reading addr 2 same cycle -> response is 1.0+j0 data.
REQ-037 done_i, out_ready_i toggling 1,0,1,0... -> rows 0..3 drained in order, stable during stalls, EMPTY after row 3 accepted, busy_o=0.
REQ-038 flush_i in ACTIVE with concurrent rd_addr_valid_i -> no rd_valid_o, EMPTY next cycle, load_ready_o=1, fresh 4-row load required before full_o.
REQ-039 rst_i during DRAIN after row 1 accepted -> out_valid_o=0 next cycle, all outputs at reset values.
